// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_ctrl_pkg : shared encodings for the branch resolution controller     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken.
  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // Unassigned funct3 codes (010, 011) resolve not-taken.
  function automatic logic br_cond_eval(input logic [2:0]  f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic r;
    case (f3)
      F3_BEQ:  r = (a == b);
      F3_BNE:  r = (a != b);
      F3_BLT:  r = ($signed(a) <  $signed(b));
      F3_BGE:  r = ($signed(a) >= $signed(b));
      F3_BLTU: r = (a <  b);
      F3_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hist_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_hist_table : 2-bit saturating counter array, async read, sync update |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module branch_hist_table
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][1:0] cnt_all;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (upd_en_i && (upd_idx_i == IDX_W'(i))) begin
        if (upd_taken_i) begin
          if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
        end else begin
          if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= BHT_CNT_RESET;
      else     cnt_q <= cnt_d;
    end

    assign cnt_all[i] = cnt_q;
  end

  // Reads the registered value, so a same-cycle update is seen one cycle later.
  assign rd_cnt_o = cnt_all[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_ctrl : IF prediction, EX branch resolution, redirect/flush control   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned BHT_IDX_W    = 6,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned      FC_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [31:0]     rpc_q, rpc_d;
  logic [31:0]     br_cnt_q, br_cnt_d;
  logic [31:0]     mis_cnt_q, mis_cnt_d;

  logic [1:0]  if_cnt;
  logic        resolve, br_resolve, br_taken, mispredict;
  logic [31:0] target;

  // Only the index bits of the fetch PC select a predictor entry.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  branch_hist_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (if_pc[BHT_IDX_W+1:2]),
    .rd_cnt_o    (if_cnt),
    .upd_en_i    (br_resolve),
    .upd_idx_i   (ex_pc[BHT_IDX_W+1:2]),
    .upd_taken_i (br_taken)
  );

  assign if_pred_taken = if_cnt[1];

  // Anything in EX while a redirect or flush is in progress is wrong-path.
  assign resolve    = ex_valid && !ex_stall && (state_q == ST_IDLE);
  assign br_resolve = resolve && ex_is_branch;
  assign br_taken   = br_cond_eval(ex_funct3, ex_rs1, ex_rs2);
  assign mispredict = resolve &&
                      (ex_is_jal || ex_is_jalr ||
                       (ex_is_branch && (br_taken != ex_pred_taken)));

  always_comb begin
    if (ex_is_jalr)
      target = (ex_rs1 + ex_imm) & ~32'd1;
    else if (ex_is_jal || (ex_is_branch && br_taken))
      target = ex_pc + ex_imm;
    else
      target = ex_pc + 32'd4;
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    rpc_d     = rpc_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (br_resolve) br_cnt_d = br_cnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d   = ST_REDIRECT;
          rpc_d     = target;
          mis_cnt_d = mis_cnt_q + 32'd1;
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q <= FC_W'(1)) state_d = ST_IDLE;
        else                    fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fcnt_q    <= '0;
      rpc_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      rpc_q     <= rpc_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign redirect_valid = (state_q == ST_REDIRECT);
  assign flush          = (state_q != ST_IDLE);
  assign redirect_pc    = rpc_q;
  assign br_count       = br_cnt_q;
  assign mispred_count  = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_ctrl : directed + random self-checking bench for branch_ctrl      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_branch_ctrl;

  localparam int IDX_W = 6;
  localparam int FC    = 2;
  localparam int NENT  = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count, mispred_count;

  branch_ctrl #(
    .BHT_IDX_W    (IDX_W),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: counter values per entry, remaining flush cycles, pending redirect.
  int          m_bht[NENT];
  int          m_busy;
  bit          m_redir;
  logic [31:0] m_rpc, m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ent(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[ent(pc)] >= 2;
  endfunction

  task automatic set_ex(input bit v, input bit st, input bit br, input bit jal, input bit jalr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input bit pred);
    ex_valid = v;  ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
  endtask

  task automatic idle_ex();
    set_ex(0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  // Advance the model over one clock edge, then compare every output.
  task automatic tick();
    int          busy_n, i;
    bit          redir_n, taken, mis;
    logic [31:0] tgt;
    if (rst) begin
      foreach (m_bht[k]) m_bht[k] = 1;
      m_busy = 0; m_redir = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    end else begin
      busy_n  = (m_busy > 0) ? m_busy - 1 : 0;
      redir_n = 0;
      if (ex_valid && !ex_stall && m_busy == 0) begin
        taken = 0;
        if (ex_is_branch) begin
          taken = cond(ex_funct3, ex_rs1, ex_rs2);
          i = ent(ex_pc);
          if (taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
          else       m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
          m_br = m_br + 1;
        end
        if (ex_is_jalr)                             tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        else if (ex_is_jal || (ex_is_branch && taken)) tgt = ex_pc + ex_imm;
        else                                        tgt = ex_pc + 32'd4;
        mis = ex_is_jal || ex_is_jalr || (ex_is_branch && (taken != ex_pred_taken));
        if (mis) begin
          m_rpc = tgt; m_mis = m_mis + 1; redir_n = 1; busy_n = FC;
        end
      end
      m_busy  = busy_n;
      m_redir = redir_n;
    end
    @(posedge clk);
    #1;
    chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
    chk("flush",          32'(flush),          32'(m_busy > 0));
    chk("redirect_pc",    redirect_pc,         m_rpc);
    chk("br_count",       br_count,            m_br);
    chk("mispred_count",  mispred_count,       m_mis);
    chk("if_pred_taken",  32'(if_pred_taken),  32'(m_pred(if_pc)));
  endtask

  initial begin
    logic [31:0] a, pc, imm;
    int          r;
    rst = 1'b1; if_pc = 32'd0; idle_ex();
    tick(); tick();
    rst = 1'b0;

    // Training one entry from weakly not-taken.
    if_pc = 32'h100;
    tick();
    chk("tp1_pred_after_reset", 32'(if_pred_taken), 32'd0);
    set_ex(1, 0, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0);
    tick(); idle_ex(); tick(); tick();
    set_ex(1, 0, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1);
    tick(); idle_ex();
    chk("tp1_pred_trained", 32'(if_pred_taken), 32'd1);
    chk("tp1_mispred", mispred_count, 32'd1);
    tick();

    // Signed vs unsigned compare on the same operands.
    set_ex(1, 0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
    tick(); idle_ex();
    chk("tp2_blt_rv",  32'(redirect_valid), 32'd1);
    chk("tp2_blt_rpc", redirect_pc, 32'h240);
    tick();
    chk("tp2_flush2_rv", 32'(redirect_valid), 32'd0);
    chk("tp2_flush2",    32'(flush), 32'd1);
    tick();
    chk("tp2_flush_done", 32'(flush), 32'd0);
    set_ex(1, 0, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
    tick(); idle_ex();
    chk("tp2_bltu_no_rv", 32'(redirect_valid), 32'd0);
    tick();

    // JALR clears bit 0; wrong-path BEQ during the flush window is ignored.
    set_ex(1, 0, 0, 0, 1, 3'd0, 32'h1003, 32'd0, 32'h400, 32'd4, 0);
    tick();
    chk("tp3_jalr_rpc", redirect_pc, 32'h1006);
    set_ex(1, 0, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h100, 32'h10, 0);
    tick(); tick(); idle_ex(); tick();

    // Stalled resolve is held off until the stall drops.
    set_ex(1, 1, 1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h500, 32'h10, 0);
    tick();
    chk("tp4_stall_no_rv", 32'(redirect_valid), 32'd0);
    ex_stall = 1'b0;
    tick(); idle_ex();
    chk("tp4_unstall_rv", 32'(redirect_valid), 32'd1);
    tick(); tick();

    // Saturation at 3, then one not-taken leaves it at 2.
    if_pc = 32'h300;
    for (int k = 0; k < 5; k++) begin
      set_ex(1, 0, 1, 0, 0, 3'd0, 32'd9, 32'd9, 32'h300, 32'h8, m_pred(32'h300));
      tick(); idle_ex(); tick(); tick();
    end
    set_ex(1, 0, 1, 0, 0, 3'd1, 32'd9, 32'd9, 32'h300, 32'h8, 1);
    tick(); idle_ex();
    chk("tp5_pred_after_nt", 32'(if_pred_taken), 32'd1);
    tick(); tick();

    // Reset landing on the REDIRECT cycle.
    set_ex(1, 0, 0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h600, 32'h80, 0);
    tick();
    chk("tp6_in_redirect", 32'(redirect_valid), 32'd1);
    rst = 1'b1; idle_ex();
    tick();
    chk("tp6_rv_cleared",  32'(redirect_valid), 32'd0);
    chk("tp6_cnt_cleared", mispred_count, 32'd0);
    for (int k = 0; k < NENT; k++) begin
      if_pc = 32'(k) << 2;
      tick();
    end
    rst = 1'b0;

    // Random mix of branches, jumps, stalls and bubbles.
    for (int k = 0; k < 600; k++) begin
      r   = $urandom_range(0, 9);
      a   = $urandom;
      pc  = 32'($urandom_range(0, 255)) << 2;
      imm = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2047)) - 32'd1024;
      set_ex($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
             r < 7, r == 7, r == 8, 3'($urandom_range(0, 7)),
             a, ($urandom_range(0, 3) == 0) ? a : $urandom, pc, imm,
             ($urandom_range(0, 9) < 7) ? m_pred(pc) : 1'($urandom_range(0, 1)));
      if_pc = 32'($urandom_range(0, 255)) << 2;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution and PC-redirect controller for the 5-stage RV32I pipeline.
- IF stage: supplies a taken/not-taken prediction from a table of 2-bit saturating counters.
- EX stage: evaluates the branch condition, detects mispredictions and issues a registered redirect plus a flush window to IF/ID.
- Also keeps branch and mispredict event counters for the CSR block.

Parameters:
- BHT_IDX_W, 6, index width of the history table (2^BHT_IDX_W entries).
- FLUSH_CYCLES, 2, cycles that flush stays asserted after a redirect (minimum 1).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- if_pc  input  32  PC of the instruction being fetched
- if_pred_taken  output  1  prediction for if_pc
- ex_valid  input  1  EX holds a live instruction
- ex_stall  input  1  EX frozen this cycle
- ex_is_branch  input  1  conditional branch in EX
- ex_is_jal  input  1  JAL in EX
- ex_is_jalr  input  1  JALR in EX
- ex_funct3  input  3  branch funct3
- ex_rs1  input  32  forwarded rs1 value
- ex_rs2  input  32  forwarded rs2 value
- ex_pc  input  32  PC of the EX instruction
- ex_imm  input  32  sign-extended immediate
- ex_pred_taken  input  1  prediction carried down the pipe with the instruction
- redirect_valid  output  1  fetch must load redirect_pc
- redirect_pc  output  32  corrected fetch address
- flush  output  1  squash IF/ID contents
- br_count  output  32  resolved conditional branches
- mispred_count  output  32  mispredicted redirects

Behaviour:
- Prediction:
  - if_pred_taken = MSB of counter[if_pc[BHT_IDX_W+1:2]]. Combinational, no bypass.
  - A same-cycle update to the same entry is not visible until the next cycle.
- Condition evaluation (funct3):
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 evaluate not-taken.
- Resolve event: ex_valid & ~ex_stall & ~squash, where squash = (state != IDLE).
- Actual target:
  - Taken branch or JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) & ~1.
  - Not-taken branch: ex_pc + 4.
  - All arithmetic is mod 2^32.
- Mispredict conditions:
  - Branch whose actual outcome differs from ex_pred_taken.
  - Any JAL or JALR, because these are not predicted.
- History update on a resolve event of a branch:
  - Counter at ex_pc index increments on taken and decrements on not-taken.
  - Counter saturates at 3 and 0.
  - Update does not depend on whether the branch mispredicted.
- State machine: IDLE, REDIRECT, FLUSH.
  - IDLE -> REDIRECT on a mispredict resolve. At the same edge, redirect_pc is registered.
  - REDIRECT, one cycle: redirect_valid=1 and flush=1.
    - If FLUSH_CYCLES=1, go to IDLE.
    - Otherwise go to FLUSH and load the down-counter with FLUSH_CYCLES-1.
  - FLUSH: flush=1 and redirect_valid=0. The counter decrements each cycle; at 1 the state returns to IDLE.
  - In REDIRECT and FLUSH, EX instructions are wrong-path. They are squashed: no update, no count, no new redirect.
  - ex_stall in IDLE: no resolve event. In the other states ex_stall is ignored (the flush proceeds).
- Counters:
  - br_count increments on each resolved branch.
  - mispred_count increments on each IDLE->REDIRECT transition.
  - Both wrap at 2^32.
- Reset, synchronous, applies even mid-redirect:
  - state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, both event counters=0.
  - All history counters = 2'b01 (weakly not-taken).
  - if_pred_taken = 0 after reset.
- Latency:
  - Redirect appears in the cycle after resolution.
  - The earliest next resolve is in the cycle after flush deasserts.

Decomposition:
- Shared package/header holds:
  - funct3 branch encodings.
  - Counter reset value 2'b01.
  - State encodings IDLE, REDIRECT, FLUSH.
- Sub-module branch_hist_table holds the counter array, with:
  - Combinational read port.
  - Saturating update port.
  - Synchronous reset of all entries.
- Condition evaluation, target arithmetic and the FSM stay in branch_ctrl.

Test Plan:
1. Reset then if_pc=0x100: expect if_pred_taken=0. Resolve a branch at 0x100 taken twice: expect if_pred_taken=1 on the cycle after the second update; mispred_count=1 (the first resolve only).
2. BLT, rs1=0xFFFFFFFF, rs2=1, pred=0, ex_pc=0x200, imm=0x40: expect next cycle redirect_valid=1, redirect_pc=0x240, flush=1 for 2 cycles. BLTU with the same operands resolves not-taken, with no redirect.
3. JALR, rs1=0x1003, imm=4: expect redirect_pc=0x1006 and mispred_count +1. A BEQ in EX during the following flush cycles: no update, no count.
4. Branch resolve with ex_stall=1: no redirect and no counter change. Deassert the stall: resolves next cycle.
5. Drive taken 5 times then not-taken once at one index: counter saturates at 3, then reads 2, and if_pred_taken stays 1.
6. Assert rst during the REDIRECT cycle: next cycle redirect_valid=0, flush=0, counters=0, all predictions 0.
